control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// control_sequencer -- hardwired Moore control unit for a single-bus datapath.
//
// Steps an instruction through fetch (T0..T2) and execute (T3..T7). Every
// output is decoded from registered state only. The instruction class and the
// ALU function are registered as T2 completes, so T3 strobes do not depend on
// live inputs.
//
// Ports
//   clock, reset_n      rising-edge clock; async active-low reset
//   ir[31:0]            instruction register (opcode = ir[31:27]); must hold
//                       the fetched instruction by the end of T2
//   mem_ready           memory handshake (used only with MEM_WAIT_EN)
//   Gra..BAout          register select/encode strobes
//   PCout..Cout         datapath strobes
//   Read, Write         memory request strobes
//   alu_op[3:0]         0 ADD, 1 SUB, 2 AND, 3 OR
//   run                 low only in HALT
//   step[3:0]           state index: RST 0, T0..T7 1..8, HALT 15
//
// Build option
//   MEM_WAIT_EN  T1, T6 (ld) and T7 (st) hold until mem_ready. When it is
//                undefined, each of those states lasts exactly one cycle.
module control_sequencer #(
  parameter logic [4:0] HALT_OP = 5'b11011
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout,
  output logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
  output logic        Yin, Zin, Zlowout, Cout,
  output logic        Read, Write,
  output logic [3:0]  alu_op,
  output logic        run,
  output logic [3:0]  step
);

  typedef enum logic [3:0] {
    S_RST = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd15
  } state_t;

  typedef enum logic [2:0] {
    C_NOP, C_RR, C_ADDI, C_LD, C_ST, C_HALT
  } cls_t;

  state_t     state, state_nx;
  cls_t       cls, cls_nx;
  logic [3:0] op_q, op_nx;
  logic       t1_first, t1_first_nx;   // PCin only on the first T1 cycle
  logic       mem_ok;

`ifdef MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  // Only the opcode field is decoded here.
  logic unused_ok;
  assign unused_ok = ^{ir[26:0], mem_ready};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_RST;
      cls      <= C_NOP;
      op_q     <= 4'd0;
      t1_first <= 1'b0;
    end else begin
      state    <= state_nx;
      cls      <= cls_nx;
      op_q     <= op_nx;
      t1_first <= t1_first_nx;
    end
  end

  // Next state
  always_comb begin
    state_nx    = state;
    cls_nx      = cls;
    op_nx       = op_q;
    t1_first_nx = 1'b0;
    case (state)
      S_RST: state_nx = S_T0;
      S_T0: begin
        state_nx    = S_T1;
        t1_first_nx = 1'b1;
      end
      S_T1: if (mem_ok) state_nx = S_T2;
      S_T2: begin
        state_nx = S_T3;
        op_nx    = 4'd0;
        if (ir[31:27] == HALT_OP) cls_nx = C_HALT;
        else begin
          case (ir[31:27])
            5'b00011: begin cls_nx = C_RR; op_nx = 4'd0; end
            5'b00100: begin cls_nx = C_RR; op_nx = 4'd1; end
            5'b00101: begin cls_nx = C_RR; op_nx = 4'd2; end
            5'b00110: begin cls_nx = C_RR; op_nx = 4'd3; end
            5'b01100: cls_nx = C_ADDI;
            5'b00000: cls_nx = C_LD;
            5'b00010: cls_nx = C_ST;
            default:  cls_nx = C_NOP;
          endcase
        end
      end
      S_T3: begin
        case (cls)
          C_NOP:   state_nx = S_T0;
          C_HALT:  state_nx = S_HALT;
          default: state_nx = S_T4;
        endcase
      end
      S_T4: state_nx = S_T5;
      S_T5: state_nx = (cls == C_LD || cls == C_ST) ? S_T6 : S_T0;
      S_T6: begin
        if (cls == C_ST || mem_ok) state_nx = S_T7;
      end
      S_T7: begin
        if (cls == C_LD || mem_ok) state_nx = S_T0;
      end
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_RST;
    endcase
  end

  // Moore outputs
  always_comb begin
    {Gra, Grb, Grc, Rin, Rout, BAout} = '0;
    {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin} = '0;
    {Yin, Zin, Zlowout, Cout, Read, Write} = '0;
    alu_op = 4'd0;
    run    = 1'b1;
    step   = state;
    case (state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCin = t1_first; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        case (cls)
          C_RR, C_ADDI: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_LD, C_ST:   begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        Zin = 1'b1;
        if (cls == C_RR) begin
          Grc = 1'b1; Rout = 1'b1; alu_op = op_q;
        end else begin
          Cout = 1'b1;   // immediate / displacement, always ADD
        end
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (cls == C_LD || cls == C_ST) MARin = 1'b1;
        else begin Gra = 1'b1; Rin = 1'b1; end
      end
      S_T6: begin
        MDRin = 1'b1;
        if (cls == C_LD) Read = 1'b1;
        else begin Gra = 1'b1; Rout = 1'b1; end
      end
      S_T7: begin
        if (cls == C_LD) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else Write = 1'b1;
      end
      S_HALT: run = 1'b0;
      default: ;
    endcase
  end

endmodule
